// File: rtl/uart_rx_if.sv
// Result bus from uart_rx_core to the register interface.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  // Handshake: rx_done is a one-cycle valid strobe with no ready; the consumer must
  // take rx_data/frame_err/parity_err on that cycle (they also hold until the next strobe).
  modport master (output rx_data, rx_done, frame_err, parity_err, busy);
  modport slave  (input  rx_data, rx_done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver: start, DATA_BITS data (LSB first), optional parity, stop.
module uart_rx_core #(
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic [1:0]       parity_mode,
  input  logic             rx,
  uart_rx_if.master        rx_bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state, state_n;
  logic       rx_meta, rx_s;
  logic [3:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic [1:0] mode, mode_n;
  logic       par_hold, par_hold_n;
  logic [7:0] data_q, data_n;
  logic       ferr_q, ferr_n;
  logic       perr_q, perr_n;
  logic       done_q, done_n;
  logic       par_en;

  // Modes 01 (even) and 10 (odd) carry a parity bit; 00 and 11 do not.
  assign par_en = mode[0] ^ mode[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      mode     <= '0;
      par_hold <= 1'b0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      mode     <= mode_n;
      par_hold <= par_hold_n;
      data_q   <= data_n;
      ferr_q   <= ferr_n;
      perr_q   <= perr_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift;
    mode_n     = mode;
    par_hold_n = par_hold;
    data_n     = data_q;
    ferr_n     = ferr_q;
    perr_n     = perr_q;
    done_n     = 1'b0;
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
            shift_n = '0;
          end
        end
        START: begin
          if (tick_cnt == 4'd7) begin
            // A start that has gone high again by mid-bit is a glitch.
            if (!rx_s) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
              mode_n  = parity_mode;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt == 4'd15) begin
            shift_n[bit_cnt] = rx_s;
            tick_n           = '0;
            if (bit_cnt == LAST_BIT) state_n = par_en ? PARITY : STOP;
            else                     bit_n   = bit_cnt + 3'd1;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (tick_cnt == 4'd15) begin
            par_hold_n = ((^shift) ^ rx_s) != (mode == 2'b10);
            tick_n     = '0;
            state_n    = STOP;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (tick_cnt == 4'd15) begin
            data_n  = shift;
            ferr_n  = ~rx_s;
            perr_n  = par_en & par_hold;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_done    = done_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.parity_err = perr_q;
  assign rx_bus.busy       = (state != IDLE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8-bit and a 7-bit receiver checked against a frame-level model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic [1:0] parity_mode;
  logic       rx, rx7;
  logic [2:0] state8, state7;
  int         tick_div = 0;

  uart_rx_if bus8();
  uart_rx_if bus7();

  uart_rx_core #(.DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .parity_mode(parity_mode),
    .rx(rx), .rx_bus(bus8), .state_dbg(state8)
  );

  uart_rx_core #(.DATA_BITS(7)) dut7 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .parity_mode(2'b00),
    .rx(rx7), .rx_bus(bus7), .state_dbg(state7)
  );

  // Clock and 16x tick, one tick every 27 clk.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div  <= (tick_div == 26) ? 0 : tick_div + 1;
    baud_tick <= (tick_div == 26);
  end

  // Expected {parity_err, frame_err, rx_data} per delivered frame.
  logic [9:0] exp_q[$];
  logic [9:0] exp7_q[$];
  logic [9:0] last_v[2];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Frame-level model: what a receiver must report for the bits that were put on the wire.
  task automatic expect_frame(input int which, input logic [7:0] d, input int nbits,
                              input logic [1:0] pm, input logic pbit, input logic stop_v);
    logic [7:0] dm;
    logic       pe;
    int         ones;
    dm   = d & 8'((1 << nbits) - 1);
    ones = $countones(dm) + int'(pbit);
    if (pm == 2'b01)      pe = (ones % 2) != 0;
    else if (pm == 2'b10) pe = (ones % 2) != 1;
    else                  pe = 1'b0;
    if (which == 0) exp_q.push_back({pe, ~stop_v, dm});
    else            exp7_q.push_back({pe, ~stop_v, dm});
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!baud_tick) @(negedge clk);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx7 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                            input logic use_par, input logic pbit, input logic stop_v);
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, d[i]);
      wait_ticks(16);
    end
    if (use_par) begin
      set_rx(which, pbit);
      wait_ticks(16);
    end
    set_rx(which, stop_v);
    wait_ticks(16);
    set_rx(which, 1'b1);
  endtask

  // Every expected frame must have been delivered by the end of its stop bit.
  task automatic chk_drained(input string nm);
    repeat (2) @(negedge clk);
    chk({nm, "_delivered"}, 32'(exp_q.size() + exp7_q.size()), 0);
    exp_q.delete();
    exp7_q.delete();
  endtask

  task automatic mon_dut(input int which, input logic done, input logic busy_v,
                         input logic [9:0] act);
    logic [9:0] e;
    logic       have;
    string      tag;
    tag  = (which == 0) ? "dut8" : "dut7";
    have = 1'b0;
    e    = '0;
    if (done) begin
      if (which == 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); have = 1'b1;
      end else if (which == 1 && exp7_q.size() > 0) begin
        e = exp7_q.pop_front(); have = 1'b1;
      end
      if (!have) begin
        n_tot++;
        $display("FAIL %s_unexpected_rx_done: got outputs 0x%0h expected no strobe", tag, act);
      end else begin
        chk({tag, "_rx_data"},    32'(act[7:0]), 32'(e[7:0]));
        chk({tag, "_frame_err"},  32'(act[8]),   32'(e[8]));
        chk({tag, "_parity_err"}, 32'(act[9]),   32'(e[9]));
        chk({tag, "_busy_at_done"}, 32'(busy_v), 0);
        last_v[which] = e;
      end
    end else begin
      chk({tag, "_hold"}, 32'(act), 32'(last_v[which]));
    end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx7 = 1'b1; parity_mode = 2'b00;
    last_v[0] = '0; last_v[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data",    32'(bus8.rx_data), 0);
    chk("reset_rx_done",    32'(bus8.rx_done), 0);
    chk("reset_frame_err",  32'(bus8.frame_err), 0);
    chk("reset_parity_err", 32'(bus8.parity_err), 0);
    chk("reset_busy",       32'(bus8.busy), 0);
    chk("reset_state",      32'(state8), 0);

    fork
      begin : main_seq
        // Plain 0x55 frame.
        wait_ticks(8);
        expect_frame(0, 8'h55, 8, 2'b00, 1'b0, 1'b1);
        send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1);
        chk_drained("f55");
        chk("f55_rx_data", 32'(bus8.rx_data), 32'h55);
        chk("f55_frame_err", 32'(bus8.frame_err), 0);
        chk("f55_busy_after", 32'(bus8.busy), 0);
        wait_ticks(16);

        // Glitch: 4 ticks low then high is rejected.
        rx = 1'b0;
        wait_ticks(4);
        chk("glitch_busy_high", 32'(bus8.busy), 1);
        rx = 1'b1;
        wait_ticks(10);
        chk("glitch_busy_low", 32'(bus8.busy), 0);
        chk("glitch_rx_data", 32'(bus8.rx_data), 32'h55);
        expect_frame(0, 8'h3C, 8, 2'b00, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
        chk_drained("f3c");
        chk("f3c_rx_data", 32'(bus8.rx_data), 32'h3C);
        wait_ticks(16);

        // Stop bit low, then a clean frame clears frame_err.
        expect_frame(0, 8'hA7, 8, 2'b00, 1'b0, 1'b0);
        send_frame(0, 8'hA7, 8, 1'b0, 1'b0, 1'b0);
        chk_drained("fa7");
        chk("fa7_rx_data", 32'(bus8.rx_data), 32'hA7);
        chk("fa7_frame_err", 32'(bus8.frame_err), 1);
        wait_ticks(16);
        chk("break_rejected_busy", 32'(bus8.busy), 0);
        expect_frame(0, 8'h01, 8, 2'b00, 1'b0, 1'b1);
        send_frame(0, 8'h01, 8, 1'b0, 1'b0, 1'b1);
        chk_drained("f01");
        chk("f01_frame_err", 32'(bus8.frame_err), 0);
        chk("f01_parity_err_disabled", 32'(bus8.parity_err), 0);
        wait_ticks(16);

        // Parity: even/ok, even/bad, odd/ok.
        parity_mode = 2'b01;
        expect_frame(0, 8'hA5, 8, 2'b01, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 8, 1'b1, 1'b0, 1'b1);
        chk_drained("even_ok");
        chk("even_ok_parity_err", 32'(bus8.parity_err), 0);
        wait_ticks(16);
        expect_frame(0, 8'hA5, 8, 2'b01, 1'b1, 1'b1);
        send_frame(0, 8'hA5, 8, 1'b1, 1'b1, 1'b1);
        chk_drained("even_bad");
        chk("even_bad_parity_err", 32'(bus8.parity_err), 1);
        wait_ticks(16);
        parity_mode = 2'b10;
        expect_frame(0, 8'hA5, 8, 2'b10, 1'b1, 1'b1);
        send_frame(0, 8'hA5, 8, 1'b1, 1'b1, 1'b1);
        chk_drained("odd_ok");
        chk("odd_ok_parity_err", 32'(bus8.parity_err), 0);
        chk("odd_ok_rx_data", 32'(bus8.rx_data), 32'hA5);
        parity_mode = 2'b00;
        wait_ticks(16);

        // Reset during data bit 3 aborts the frame.
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
          rx = 1'(8'h96 >> i);
          wait_ticks(16);
        end
        rx = 1'b0;
        wait_ticks(8);
        chk("rst_busy_mid_frame", 32'(bus8.busy), 1);
        rst = 1'b1; rx = 1'b1;
        last_v[0] = '0; last_v[1] = '0;
        exp_q.delete(); exp7_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_data",    32'(bus8.rx_data), 0);
        chk("rst_frame_err",  32'(bus8.frame_err), 0);
        chk("rst_parity_err", 32'(bus8.parity_err), 0);
        chk("rst_busy",       32'(bus8.busy), 0);
        wait_ticks(32);
        chk("rst_no_late_done_busy", 32'(bus8.busy), 0);
        expect_frame(0, 8'hC3, 8, 2'b00, 1'b0, 1'b1);
        send_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1'b1);
        chk_drained("fc3");
        chk("fc3_rx_data", 32'(bus8.rx_data), 32'hC3);
        wait_ticks(16);

        // Back-to-back frames with no idle gap.
        expect_frame(0, 8'h00, 8, 2'b00, 1'b0, 1'b1);
        expect_frame(0, 8'hFF, 8, 2'b00, 1'b0, 1'b1);
        send_frame(0, 8'h00, 8, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 8, 1'b0, 1'b0, 1'b1);
        chk_drained("b2b");
        chk("b2b_rx_data", 32'(bus8.rx_data), 32'hFF);
        wait_ticks(16);

        // 7-bit receiver: upper bit of rx_data stays 0.
        expect_frame(1, 8'h7F, 7, 2'b00, 1'b0, 1'b1);
        send_frame(1, 8'h7F, 7, 1'b0, 1'b0, 1'b1);
        chk_drained("f7f");
        chk("f7f_rx_data", 32'(bus7.rx_data), 32'h7F);
        chk("f7f_bit7", 32'(bus7.rx_data[7]), 0);
        chk("f7f_busy", 32'(bus7.busy), 0);
        wait_ticks(4);
      end
      begin : compare
        forever begin
          @(posedge clk);
          #3;
          mon_dut(0, bus8.rx_done, bus8.busy, {bus8.parity_err, bus8.frame_err, bus8.rx_data});
          mon_dut(1, bus7.rx_done, bus7.busy, {bus7.parity_err, bus7.frame_err, bus7.rx_data});
        end
      end
    join_any

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver for the peripheral UART block, the receive-side counterpart of the TX path. It consumes the shared 16x-oversampling `baud_tick` produced by the baud generator and deserialises one asynchronous frame from `rx`: 1 start bit, DATA_BITS data bits LSB-first, optional parity, and 1 stop bit. Each received byte is presented on `rx_data` with a one-cycle `rx_done` strobe and per-frame error flags for the bus-facing register interface.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; synchronous, active-high.
- baud_tick  in  1  16x-oversample enable, one clk cycle wide.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; latched at start-bit confirmation.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last received word, right-aligned; bits above DATA_BITS are 0.
- rx_done  out  1  one-cycle strobe: rx_data and the error flags were updated.
- frame_err  out  1  the last frame's stop bit was sampled low.
- parity_err  out  1  the last frame's parity bit mismatched; 0 when parity is disabled.
- busy  out  1  high whenever state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised `rx_s`.
- Internal counters:
  - `tick_cnt` is 4 bits, counts baud_ticks within a bit, and wraps 15->0.
  - `bit_cnt` is 3 bits, counts data bits.
- The FSM advances only on clk edges where baud_tick=1. Its states are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - When baud_tick=1 and rx_s=0: go to START, set tick_cnt=0, clear the shift register.
- START:
  - On each tick, tick_cnt increments.
  - When tick_cnt=7 (mid start bit) and rx_s=0: go to DATA, set tick_cnt=0 and bit_cnt=0, latch parity_mode.
  - When tick_cnt=7 and rx_s=1: this is a glitch. Go to IDLE with no strobe and no flag change.
- DATA:
  - When tick_cnt=15 (mid bit): write shift[bit_cnt]=rx_s and set tick_cnt=0.
  - If bit_cnt=DATA_BITS-1, go to PARITY when the latched mode is 01 or 10, otherwise go to STOP.
  - Otherwise, increment bit_cnt.
- PARITY:
  - When tick_cnt=15: compute the error flag.
    - Even mode: error = XOR(data bits) ^ rx_s ≠ 0.
    - Odd mode: error = XOR(data bits) ^ rx_s ≠ 1.
  - Hold the result internally, set tick_cnt=0, go to STOP.
- STOP:
  - When tick_cnt=15: update the outputs and go to IDLE.
    - rx_data = shift.
    - frame_err = ~rx_s.
    - parity_err = the held result, or 0 when parity is disabled.
    - rx_done = 1.
  - Data is delivered even when frame_err=1.
- Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught with no lost bits.
- If rx_s is still low in IDLE after a frame error (break condition), that is treated as a new start bit. It is rejected or accepted by the START check like any other start.
- Reset mid-frame: go to IDLE immediately, with no rx_done and no flag update. The next valid frame is received normally.

## Timing
- Values after rst:
  - state IDLE
  - rx_data=0x00
  - rx_done=0
  - frame_err=0
  - parity_err=0
  - busy=0
  - tick_cnt=0, bit_cnt=0
- Input latency: 2 clk from `rx` to `rx_s`.
- rx_done, rx_data, frame_err and parity_err are registered on the clk edge where the STOP tick_cnt=15 sample is taken. rx_done is high for exactly the following clk cycle and is cleared on the next edge regardless of baud_tick.
- rx_data, frame_err and parity_err hold until the next rx_done. Rejected starts do not change them.
- Frame duration from the confirmed start midpoint to rx_done is 16 × (DATA_BITS + P + 1) ticks, where P=1 when parity is enabled. In clk cycles this is that count times the tick period, +1.
- busy rises on the edge that enters START. It falls on the edge that sets rx_done.
- A change on parity_mode during a frame has no effect until the next start is confirmed.

## Test plan
- Frame 0x55, no parity, 16 ticks/bit, baud_tick every 27 clk -> exactly one rx_done, rx_data=0x55, frame_err=0, parity_err=0, busy low afterwards.
- rx low for 4 ticks then high -> no rx_done, busy high then back to 0, rx_data unchanged. A following frame 0x3C is received correctly.
- Frame 0xA7 with the stop bit driven low -> rx_done with rx_data=0xA7, frame_err=1. The next clean frame 0x01 clears frame_err to 0.
- parity_mode=01 with 0xA5 and parity bit 0 -> parity_err=0. Same frame with parity bit 1 -> parity_err=1. parity_mode=10 with 0xA5 and parity bit 1 -> parity_err=0.
- rst asserted for 1 clk during data bit 3 of a frame -> no rx_done, outputs at reset values. The next frame 0xC3 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap, then DATA_BITS=7 frame 0x7F -> two rx_done strobes with correct data, then rx_data=0x7F with bit 7 = 0.
